// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, per-stage control bundle, NOP word.
// Pure declarations; no logic, no latency, no flow control.
package pipe_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        BRWAIT = 3'd1,
        IMISS  = 3'd2,
        DMISS  = 3'd3,
        HALT   = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Encoding the IF/ID and ID/EX consumers load on fd_flush / dx_bubble (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic fd_flush;
        logic dx_en;
        logic dx_bubble;
        logic xm_en;
        logic mw_en;
    } ctrl_t;

    function automatic ctrl_t ctrl_all(input logic en);
        ctrl_t c;
        c.pc_en     = en;
        c.fd_en     = en;
        c.fd_flush  = 1'b0;
        c.dx_en     = en;
        c.dx_bubble = 1'b0;
        c.xm_en     = en;
        c.mw_en     = en;
        return c;
    endfunction

    // Front end held, a bubble enters EX, back end keeps draining.
    function automatic ctrl_t ctrl_stall();
        ctrl_t c;
        c           = ctrl_all(1'b1);
        c.pc_en     = 1'b0;
        c.fd_en     = 1'b0;
        c.dx_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall-cycle performance count.
// Counts on the edge after i_inc; no backpressure, holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: turns hazard/miss/halt events into per-stage enables, flushes and bubbles.
// Enables are combinational from inputs and state; multi-cycle stalls are sequenced by the FSM.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int BR_STALLS = 2,
    parameter int DRAIN_CYC = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_use,
    input  logic             br_dep,
    input  logic             br_taken,
    input  logic             hlt_id,
    input  logic             imiss,
    input  logic             iready,
    input  logic             dmiss,
    input  logic             dready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dx_en,
    output logic             dx_bubble,
    output logic             xm_en,
    output logic             mw_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_e               r_state;
    state_e               r_ret_state;
    logic [1:0]           r_br_cnt;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_iready_seen;

    state_e               w_nxt_state;
    state_e               w_nxt_ret;
    logic [1:0]           w_nxt_br_cnt;
    logic [DRAIN_W-1:0]   w_nxt_drain;
    logic                 w_nxt_iready_seen;
    ctrl_t                w_ctrl;
    logic                 w_stall_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_ret_state   <= RUN;
            r_br_cnt      <= '0;
            r_drain_cnt   <= '0;
            r_iready_seen <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_ret_state   <= w_nxt_ret;
            r_br_cnt      <= w_nxt_br_cnt;
            r_drain_cnt   <= w_nxt_drain;
            r_iready_seen <= w_nxt_iready_seen;
        end
    end

    always_comb begin
        w_ctrl            = ctrl_all(1'b1);
        w_nxt_state       = r_state;
        w_nxt_ret         = r_ret_state;
        w_nxt_br_cnt      = r_br_cnt;
        w_nxt_drain       = r_drain_cnt;
        w_nxt_iready_seen = r_iready_seen;

        unique case (r_state)
            RUN: begin
                if (dmiss) begin
                    w_ctrl            = ctrl_all(1'b0);
                    w_nxt_state       = DMISS;
                    w_nxt_ret         = RUN;
                    w_nxt_iready_seen = 1'b0;
                end else if (ld_use) begin
                    w_ctrl = ctrl_stall();
                end else if (br_dep) begin
                    // The br_dep cycle itself is the first of the BR_STALLS stall cycles.
                    w_ctrl       = ctrl_stall();
                    w_nxt_br_cnt = 2'(BR_STALLS - 1);
                    if (BR_STALLS > 1) begin
                        w_nxt_state = BRWAIT;
                    end
                end else if (hlt_id) begin
                    w_ctrl.pc_en    = 1'b0;
                    w_ctrl.fd_flush = 1'b1;
                    w_nxt_drain     = DRAIN_W'(DRAIN_CYC - 1);
                    w_nxt_state     = HALT;
                end else if (br_taken) begin
                    w_ctrl.fd_flush = 1'b1;
                    if (imiss) begin
                        w_nxt_state = IMISS;
                    end
                end else if (imiss) begin
                    w_ctrl      = ctrl_stall();
                    w_nxt_state = IMISS;
                end
            end

            BRWAIT: begin
                if (dmiss) begin
                    w_ctrl      = ctrl_all(1'b0);
                    w_nxt_state = DMISS;
                    w_nxt_ret   = BRWAIT;
                end else begin
                    w_ctrl       = ctrl_stall();
                    w_nxt_br_cnt = r_br_cnt - 2'd1;
                    if (r_br_cnt <= 2'd1) begin
                        w_nxt_state = RUN;
                    end
                end
            end

            IMISS: begin
                if (dmiss) begin
                    w_ctrl            = ctrl_all(1'b0);
                    w_nxt_state       = DMISS;
                    w_nxt_ret         = IMISS;
                    w_nxt_iready_seen = iready;
                end else begin
                    w_ctrl = ctrl_stall();
                    if (iready) begin
                        w_nxt_state = RUN;
                    end
                end
            end

            DMISS: begin
                w_ctrl = ctrl_all(1'b0);
                if (iready && (r_ret_state == IMISS)) begin
                    w_nxt_iready_seen = 1'b1;
                end
                if (dready) begin
                    w_nxt_iready_seen = 1'b0;
                    // A fill that completed under the D-miss retires the I-miss on the way back.
                    if ((r_ret_state == IMISS) && (r_iready_seen || iready)) begin
                        w_nxt_state = RUN;
                    end else begin
                        w_nxt_state = r_ret_state;
                    end
                end
            end

            HALT: begin
                if (dmiss) begin
                    w_ctrl      = ctrl_all(1'b0);
                    w_nxt_state = DMISS;
                    w_nxt_ret   = HALT;
                end else begin
                    w_ctrl = ctrl_stall();
                    if (r_drain_cnt == '0) begin
                        w_nxt_state = DONE;
                    end else begin
                        w_nxt_drain = r_drain_cnt - DRAIN_W'(1);
                    end
                end
            end

            DONE: begin
                w_ctrl = ctrl_all(1'b0);
            end

            default: begin
                w_nxt_state = RUN;
            end
        endcase

        if (!rst_n) begin
            w_ctrl = ctrl_all(1'b1);
        end
    end

    assign w_stall_inc = !w_ctrl.pc_en && (r_state != HALT) && (r_state != DONE);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    assign pc_en     = w_ctrl.pc_en;
    assign fd_en     = w_ctrl.fd_en;
    assign fd_flush  = w_ctrl.fd_flush;
    assign dx_en     = w_ctrl.dx_en;
    assign dx_bubble = w_ctrl.dx_bubble;
    assign xm_en     = w_ctrl.xm_en;
    assign mw_en     = w_ctrl.mw_en;
    assign halted    = (r_state == DONE);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: driver queues hand-computed expectations, monitor checks each cycle.
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 16;

    // {pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_en, mw_en}
    localparam logic [6:0] C_RUN   = 7'b1101011;
    localparam logic [6:0] C_STALL = 7'b0001111;
    localparam logic [6:0] C_FRZ   = 7'b0000000;
    localparam logic [6:0] C_TAKEN = 7'b1111011;
    localparam logic [6:0] C_HLT   = 7'b0111011;

    // input vector: {ld_use, br_dep, br_taken, hlt_id, imiss, iready, dmiss, dready}
    localparam logic [7:0] I_NONE  = 8'b0000_0000;
    localparam logic [7:0] I_LDU   = 8'b1000_0000;
    localparam logic [7:0] I_BRDEP = 8'b0100_0000;
    localparam logic [7:0] I_TAKEN = 8'b0010_0000;
    localparam logic [7:0] I_HLT   = 8'b0001_0000;
    localparam logic [7:0] I_IMISS = 8'b0000_1000;
    localparam logic [7:0] I_IRDY  = 8'b0000_0100;
    localparam logic [7:0] I_DMISS = 8'b0000_0010;
    localparam logic [7:0] I_DRDY  = 8'b0000_0001;

    typedef struct {
        int          id;
        logic [6:0]  ctrl;
        logic        hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ld_use = 1'b0, br_dep = 1'b0, br_taken = 1'b0, hlt_id = 1'b0;
    logic imiss = 1'b0, iready = 1'b0, dmiss = 1'b0, dready = 1'b0;
    logic pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_en, mw_en, halted;
    logic [CNT_W-1:0] stall_cnt;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   row = 0;
    bit   drv_done = 1'b0;

    pipe_stall_ctrl #(
        .BR_STALLS (2),
        .DRAIN_CYC (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_use    (ld_use),
        .br_dep    (br_dep),
        .br_taken  (br_taken),
        .hlt_id    (hlt_id),
        .imiss     (imiss),
        .iready    (iready),
        .dmiss     (dmiss),
        .dready    (dready),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .fd_flush  (fd_flush),
        .dx_en     (dx_en),
        .dx_bubble (dx_bubble),
        .xm_en     (xm_en),
        .mw_en     (mw_en),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, so reset edges land mid-cycle.
    task automatic step(input logic r, input logic [7:0] in, input logic [6:0] ctrl,
                        input logic h, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        {ld_use, br_dep, br_taken, hlt_id, imiss, iready, dmiss, dready} = in;
        e.id   = row;
        e.ctrl = ctrl;
        e.hlt  = h;
        e.cnt  = CNT_W'(cnt);
        q.push_back(e);
        row++;
    endtask

    initial begin : monitor
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_en, mw_en};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL row%0d ctrl: got %b want %b", e.id, act, e.ctrl);
                end
                checks++;
                if (halted !== e.hlt) begin
                    errors++;
                    $display("FAIL row%0d halted: got %b want %b", e.id, halted, e.hlt);
                end
                checks++;
                if (stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL row%0d stall_cnt: got %0d want %0d", e.id, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish, rows pushed %0d", row);
        $fatal(1, "timeout");
    end

    initial begin : driver
        // reset state
        step(1'b0, I_NONE,  C_RUN,   1'b0, 0);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 0);
        // load-use: single stall cycle
        step(1'b1, I_LDU,   C_STALL, 1'b0, 0);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 1);
        // branch dependency, BR_STALLS=2, then taken branch on the third cycle
        step(1'b1, I_BRDEP, C_STALL, 1'b0, 1);
        step(1'b1, I_NONE,  C_STALL, 1'b0, 2);
        step(1'b1, I_TAKEN, C_TAKEN, 1'b0, 3);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 3);
        // stall beats a simultaneous taken branch
        step(1'b1, I_LDU | I_TAKEN, C_STALL, 1'b0, 3);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 4);
        // nested miss: imiss, dmiss two cycles later, iready under DMISS, dready
        step(1'b1, I_IMISS, C_STALL, 1'b0, 4);
        step(1'b1, I_NONE,  C_STALL, 1'b0, 5);
        step(1'b1, I_DMISS, C_FRZ,   1'b0, 6);
        step(1'b1, I_IRDY,  C_FRZ,   1'b0, 7);
        step(1'b1, I_NONE,  C_FRZ,   1'b0, 8);
        step(1'b1, I_DRDY,  C_FRZ,   1'b0, 9);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 10);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 10);
        // taken branch with imiss redirects the PC, then a plain I-miss wait
        step(1'b1, I_TAKEN | I_IMISS, C_TAKEN, 1'b0, 10);
        step(1'b1, I_NONE,  C_STALL, 1'b0, 10);
        step(1'b1, I_IRDY,  C_STALL, 1'b0, 11);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 12);
        // stray dready in RUN is ignored
        step(1'b1, I_DRDY,  C_RUN,   1'b0, 12);
        // priority conflict: dmiss + ld_use + br_taken
        step(1'b1, I_DMISS | I_LDU | I_TAKEN, C_FRZ, 1'b0, 12);
        step(1'b1, I_NONE,  C_FRZ,   1'b0, 13);
        step(1'b1, I_DRDY,  C_FRZ,   1'b0, 14);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 15);
        // dmiss inside BRWAIT holds br_cnt and returns to BRWAIT
        step(1'b1, I_BRDEP, C_STALL, 1'b0, 15);
        step(1'b1, I_DMISS, C_FRZ,   1'b0, 16);
        step(1'b1, I_DRDY,  C_FRZ,   1'b0, 17);
        step(1'b1, I_NONE,  C_STALL, 1'b0, 18);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 19);
        // async reset mid-DMISS, dready after release ignored
        step(1'b1, I_DMISS, C_FRZ,   1'b0, 19);
        step(1'b1, I_NONE,  C_FRZ,   1'b0, 20);
        step(1'b0, I_NONE,  C_RUN,   1'b0, 0);
        step(1'b1, I_DRDY,  C_RUN,   1'b0, 0);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 0);
        // halt: flush cycle, four drain cycles, then DONE; counter frozen while draining
        step(1'b1, I_HLT,   C_HLT,   1'b0, 0);
        step(1'b1, I_NONE,  C_STALL, 1'b0, 1);
        step(1'b1, I_NONE,  C_STALL, 1'b0, 1);
        step(1'b1, I_NONE,  C_STALL, 1'b0, 1);
        step(1'b1, I_NONE,  C_STALL, 1'b0, 1);
        step(1'b1, I_NONE,  C_FRZ,   1'b1, 1);
        step(1'b1, I_LDU | I_IMISS | I_DRDY, C_FRZ, 1'b1, 1);
        step(1'b1, I_NONE,  C_FRZ,   1'b1, 1);
        // only reset leaves DONE
        step(1'b0, I_NONE,  C_RUN,   1'b0, 0);
        step(1'b1, I_NONE,  C_RUN,   1'b0, 0);
        drv_done = 1'b1;

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
